// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax downscale/exp sequencing logic.
package softmax_pkg;

  typedef enum logic [1:0] {
    StFill,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

  localparam int unsigned DefaultDataSize      = 32;
  localparam int unsigned DefaultNumberOfData  = 10;
  localparam int unsigned DefaultTimeoutCycles = 256;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// N-entry sample store: synchronous write, registered read.
module frame_buffer #(
  parameter int unsigned data_size = 32,
  parameter int unsigned depth     = 10,
  localparam int unsigned IdxW     = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                 clock_i,
  input  logic                 wr_en_i,
  input  logic [IdxW-1:0]      wr_idx_i,
  input  logic [data_size-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [IdxW-1:0]      rd_idx_i,
  output logic [data_size-1:0] rd_data_o
);

  logic [data_size-1:0] mem_q [depth];
  logic [data_size-1:0] rd_data_q;

  // Contents are never reset; the scheduler only reads entries it has written.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/softmax_frame_scheduler.sv
// Collects one frame of samples, replays it to downscale, then forwards and counts exp results.
module softmax_frame_scheduler
  import softmax_pkg::*;
#(
  parameter int unsigned data_size      = DefaultDataSize,
  parameter int unsigned number_of_data = DefaultNumberOfData,
  parameter int unsigned timeout_cycles = DefaultTimeoutCycles
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  input  logic [data_size-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 ds_start_o,
  output logic [data_size-1:0] ds_data_o,
  output logic                 ds_valid_o,
  input  logic                 exp_valid_i,
  input  logic [data_size-1:0] exp_data_i,
  output logic                 out_valid_o,
  output logic [data_size-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CntW  = cnt_width(number_of_data);
  localparam int unsigned IdleW = cnt_width(timeout_cycles);
  localparam int unsigned IdxW  = (number_of_data > 1) ? $clog2(number_of_data) : 1;

  localparam logic [CntW-1:0]  LastIdx  = CntW'(number_of_data - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(timeout_cycles - 1);

  sched_state_e state_q, state_d;

  logic [CntW-1:0]  wr_cnt_q, rd_cnt_q, iss_cnt_q;
  logic [IdleW-1:0] idle_q;

  logic accept, last_accept, last_issue, last_result, timeout, fwd;
  logic                 buf_rd_en;
  logic [CntW-1:0]      buf_rd_idx;
  logic [data_size-1:0] buf_rd_data;

  logic                 ds_valid_q, ds_start_q;
  logic                 out_valid_q, out_last_q, err_q;
  logic [data_size-1:0] out_data_q;
  logic                 in_ready, busy, frame_done;

  assign accept      = (state_q == StFill) && in_valid_i;
  assign last_accept = accept && (wr_cnt_q == LastIdx);
  assign last_issue  = (state_q == StIssue) && (iss_cnt_q == LastIdx);
  assign fwd         = (state_q == StDrain) && exp_valid_i;
  assign last_result = fwd && (rd_cnt_q == LastIdx);
  assign timeout     = (state_q == StDrain) && !exp_valid_i && (idle_q == IdleLast);

  // Entry 0 is prefetched on the final accept so the replay starts the very next cycle.
  assign buf_rd_en  = last_accept || ((state_q == StIssue) && !last_issue);
  assign buf_rd_idx = last_accept ? '0 : iss_cnt_q + 1'b1;

  frame_buffer #(
    .data_size (data_size),
    .depth     (number_of_data)
  ) u_frame_buffer (
    .clock_i   (clock_i),
    .wr_en_i   (accept),
    .wr_idx_i  (wr_cnt_q[IdxW-1:0]),
    .wr_data_i (in_data_i),
    .rd_en_i   (buf_rd_en),
    .rd_idx_i  (buf_rd_idx[IdxW-1:0]),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (last_accept) state_d = StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (last_result || timeout) state_d = StDone;
      StDone:  state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Outputs are forced low while reset is asserted, not just after it is sampled.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StFill:           in_ready = 1'b1;
        StIssue, StDrain: busy = 1'b1;
        StDone: begin
          busy       = 1'b1;
          frame_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counters return to zero whenever their owning state is left.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_cnt_q  <= '0;
      iss_cnt_q <= '0;
      rd_cnt_q  <= '0;
      idle_q    <= '0;
    end else begin
      if (last_accept) begin
        wr_cnt_q <= '0;
      end else if (accept) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end

      if (state_q == StIssue) begin
        iss_cnt_q <= last_issue ? '0 : iss_cnt_q + 1'b1;
      end

      if (last_result || timeout) begin
        rd_cnt_q <= '0;
      end else if (fwd) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end

      if (state_q == StDrain) begin
        idle_q <= (exp_valid_i || timeout) ? '0 : idle_q + 1'b1;
      end else begin
        idle_q <= '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ds_valid_q  <= 1'b0;
      ds_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ds_valid_q  <= buf_rd_en;
      ds_start_q  <= last_accept;
      out_valid_q <= fwd;
      out_data_q  <= fwd ? exp_data_i : '0;
      out_last_q  <= last_result;
      // Results arriving outside DRAIN are dropped and flagged.
      err_q       <= err_q | (exp_valid_i && (state_q != StDrain)) | timeout;
    end
  end

  assign in_ready_o   = in_ready;
  assign busy_o       = busy;
  assign frame_done_o = frame_done;
  assign ds_valid_o   = ds_valid_q && !reset_i;
  assign ds_start_o   = ds_start_q && !reset_i;
  assign ds_data_o    = (ds_valid_q && !reset_i) ? buf_rd_data : '0;
  assign out_valid_o  = out_valid_q && !reset_i;
  assign out_data_o   = reset_i ? '0 : out_data_q;
  assign out_last_o   = out_last_q && !reset_i;
  assign err_o        = err_q && !reset_i;

endmodule

// File: tb/tb_softmax_frame_scheduler.sv
// Directed bench for softmax_frame_scheduler: fill, replay, drain, timeout, error and reset cases.
module tb_softmax_frame_scheduler;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        ds_start_o;
  logic [31:0] ds_data_o;
  logic        ds_valid_o;
  logic        exp_valid_i;
  logic [31:0] exp_data_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  softmax_frame_scheduler #(
    .data_size      (32),
    .number_of_data (10),
    .timeout_cycles (256)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .ds_start_o   (ds_start_o),
    .ds_data_o    (ds_data_o),
    .ds_valid_o   (ds_valid_o),
    .exp_valid_i  (exp_valid_i),
    .exp_data_i   (exp_data_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Enters at a falling edge in FILL; leaves at the falling edge after the last accept.
  task automatic fill(input int base, input int gap);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        in_valid_i = 1'b0;
        repeat (gap) @(negedge clock_i);
      end
      in_valid_i = 1'b1;
      in_data_i  = base + i;
      #1;
      check("fill_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("fill_ds_idle", {31'd0, ds_valid_o}, 32'd0);
      @(negedge clock_i);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic check_issue(input int base);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("issue_ds_valid", {31'd0, ds_valid_o}, 32'd1);
      check("issue_ds_start", {31'd0, ds_start_o}, (k == 0) ? 32'd1 : 32'd0);
      check("issue_ds_data", ds_data_o, base + k);
      check("issue_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("issue_busy", {31'd0, busy_o}, 32'd1);
      @(negedge clock_i);
    end
    #1;
    check("issue_end_valid", {31'd0, ds_valid_o}, 32'd0);
    check("issue_end_start", {31'd0, ds_start_o}, 32'd0);
  endtask

  // Sends n_res results with random gaps; checks each forwarded one cycle later.
  task automatic run_drain(input int n_res, input int max_gap, input int base);
    bit full;
    for (int r = 0; r < n_res; r++) begin
      repeat ($urandom_range(0, max_gap)) begin
        exp_valid_i = 1'b0;
        @(negedge clock_i);
        #1;
        check("drain_gap_out_valid", {31'd0, out_valid_o}, 32'd0);
      end
      exp_valid_i = 1'b1;
      exp_data_i  = base + r;
      @(negedge clock_i);
      exp_valid_i = 1'b0;
      #1;
      full = (n_res == 10) && (r == 9);
      check("drain_out_valid", {31'd0, out_valid_o}, 32'd1);
      check("drain_out_data", out_data_o, base + r);
      check("drain_out_last", {31'd0, out_last_o}, {31'd0, full});
      check("drain_frame_done", {31'd0, frame_done_o}, {31'd0, full});
      check("drain_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("drain_err", {31'd0, err_o}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i     = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    exp_valid_i = 1'b0;
    exp_data_i  = '0;
    repeat (2) @(negedge clock_i);
    #1;
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ds_valid", {31'd0, ds_valid_o}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    reset_i = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);

    // Frame 1: continuous upstream, exp results with random gaps.
    fill(1, 0);
    check_issue(1);
    run_drain(10, 20, 32'hE000_0000);
    @(negedge clock_i);
    #1;
    check("done1_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("done1_frame_done", {31'd0, frame_done_o}, 32'd0);
    check("done1_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("done1_err", {31'd0, err_o}, 32'd0);

    // Frame 2: upstream every third cycle, only nine results -> drain timeout.
    fill(11, 2);
    check_issue(11);
    run_drain(9, 0, 32'hA000_0000);
    repeat (255) @(negedge clock_i);
    #1;
    check("pre_timeout_done", {31'd0, frame_done_o}, 32'd0);
    check("pre_timeout_err", {31'd0, err_o}, 32'd0);
    check("pre_timeout_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clock_i);
    #1;
    check("timeout_frame_done", {31'd0, frame_done_o}, 32'd1);
    check("timeout_err", {31'd0, err_o}, 32'd1);
    check("timeout_out_last", {31'd0, out_last_o}, 32'd0);
    check("timeout_out_valid", {31'd0, out_valid_o}, 32'd0);
    @(negedge clock_i);
    #1;
    check("after_timeout_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("after_timeout_err_sticky", {31'd0, err_o}, 32'd1);
    check("after_timeout_done", {31'd0, frame_done_o}, 32'd0);

    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check("rst_clears_err", {31'd0, err_o}, 32'd0);

    // Stray exp result during FILL.
    exp_valid_i = 1'b1;
    exp_data_i  = 32'h5555_AAAA;
    @(negedge clock_i);
    exp_valid_i = 1'b0;
    #1;
    check("stray_not_forwarded", {31'd0, out_valid_o}, 32'd0);
    check("stray_err", {31'd0, err_o}, 32'd1);
    check("stray_in_ready", {31'd0, in_ready_o}, 32'd1);
    repeat (3) @(negedge clock_i);
    #1;
    check("stray_err_sticky", {31'd0, err_o}, 32'd1);

    // Reset during the fifth replayed sample.
    fill(21, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("abort_ds_data", ds_data_o, 21 + k);
      if (k < 4) @(negedge clock_i);
    end
    reset_i = 1'b1;
    #1;
    check("abort_rst_ds_valid", {31'd0, ds_valid_o}, 32'd0);
    check("abort_rst_ds_data", ds_data_o, 32'd0);
    check("abort_rst_busy", {31'd0, busy_o}, 32'd0);
    check("abort_rst_err", {31'd0, err_o}, 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check("abort_ds_valid", {31'd0, ds_valid_o}, 32'd0);
    check("abort_ds_start", {31'd0, ds_start_o}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_err", {31'd0, err_o}, 32'd0);
    check("abort_frame_done", {31'd0, frame_done_o}, 32'd0);
    repeat (3) @(negedge clock_i);
    #1;
    check("abort_still_idle", {31'd0, ds_valid_o}, 32'd0);

    // Fresh frame after the abort.
    fill(31, 0);
    check_issue(31);
    run_drain(10, 3, 32'hC000_0000);
    @(negedge clock_i);
    #1;
    check("done4_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("done4_err", {31'd0, err_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/softmax_frame_scheduler.md
# softmax_frame_scheduler

Sequencing controller for the softmax downscale → exp datapath. It collects one frame of `number_of_data` samples from an upstream valid/ready stream into a local buffer and replays them back-to-back to the downscale stage with a start pulse. It then counts the exp results and tags the final one, and reports frame completion and protocol errors. It sits between the upstream producer and the downscale/exp pair; the exp results pass through it to the normalisation stage.

## Interface
- `data_size`, 32, sample width in bits (same for input and exp result)
- `number_of_data`, 10, samples per frame (N ≥ 2)
- `timeout_cycles`, 256, maximum idle cycles between exp results while draining
- `clock_i`  in  1  single clock, rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `in_valid_i`  in  1  upstream sample valid
- `in_data_i`  in  data_size  upstream sample
- `in_ready_o`  out  1  scheduler accepts a sample this cycle
- `ds_start_o`  out  1  one-cycle frame-start pulse to downscale, coincident with first sample
- `ds_data_o`  out  data_size  sample to downscale
- `ds_valid_o`  out  1  `ds_data_o` valid; high for exactly N consecutive cycles per frame
- `exp_valid_i`  in  1  exp result valid
- `exp_data_i`  in  data_size  exp result
- `out_valid_o`  out  1  forwarded exp result valid
- `out_data_o`  out  data_size  forwarded exp result
- `out_last_o`  out  1  marks the Nth result of the frame
- `frame_done_o`  out  1  one-cycle pulse at frame completion
- `busy_o`  out  1  high in ISSUE, DRAIN and DONE
- `err_o`  out  1  sticky: exp result outside DRAIN, or drain timeout; cleared only by reset

## Operation
- FSM states: FILL (reset state), ISSUE, DRAIN, DONE.
- FILL:
  - `in_ready_o` = 1.
  - Each `in_valid_i && in_ready_o` writes the sample to `buf[wr_cnt]` and increments `wr_cnt`.
  - On the Nth accept, go to ISSUE. Upstream gaps are allowed.
- ISSUE:
  - `in_ready_o` = 0.
  - Registered outputs present `buf[0..N-1]` on N consecutive cycles with `ds_valid_o` = 1.
  - `ds_start_o` = 1 only with `buf[0]`.
  - After the Nth sample, go to DRAIN. No stall is possible.
- DRAIN:
  - Each `exp_valid_i` is registered to `out_valid_o`/`out_data_o` one cycle later and increments `rd_cnt`.
  - `out_last_o` = 1 with the Nth result.
  - On the Nth `exp_valid_i`, go to DONE.
  - Idle counter resets on every `exp_valid_i`. If it reaches `timeout_cycles`, set `err_o` and go to DONE without `out_last_o`.
- DONE: `frame_done_o` = 1 for one cycle; clear `wr_cnt`/`rd_cnt`; go to FILL.
- `exp_valid_i` in FILL, ISSUE or DONE: the result is not forwarded and `err_o` is set. Results beyond N cannot occur in DRAIN because the FSM leaves DRAIN on the Nth.
- Counters: `wr_cnt`, `rd_cnt` are `$clog2(N+1)` bits. Idle counter is `$clog2(timeout_cycles+1)` bits. No wrap; every counter is cleared on state exit.
- Buffer: N × `data_size` register array; no reset needed on contents.

## Timing
- Reset (any cycle, including mid-frame):
  - Next state is FILL; all counters 0; buffer contents discarded.
  - All outputs 0 during the reset cycle. `in_ready_o` = 1 from the first cycle after reset deasserts.
- Last sample accepted at cycle t:
  - `ds_start_o`/`ds_valid_o` first high at t+1; last sample at t+N.
  - DRAIN begins at t+N+1.
- Nth `exp_valid_i` at cycle d: `out_valid_o` & `out_last_o` & `frame_done_o` all high at d+1 (DONE); `in_ready_o` = 1 at d+2.
- Forwarding latency: exactly 1 cycle.
- `busy_o` is the complement of `in_ready_o` outside reset.

## Structure
- Shared package `softmax_pkg`: state enum (FILL/ISSUE/DRAIN/DONE), default `data_size`, `number_of_data`, `timeout_cycles` constants, counter-width function.
- Natural sub-module: `frame_buffer` (N-entry register array with write index / read index, synchronous write, registered read). FSM and counters stay in the top module.

## Test plan
- Reset, then N=10 samples 1..10 with `in_valid_i` continuous:
  - 10 accepts, then `ds_start_o` one cycle with data 1.
  - `ds_valid_o` high 10 cycles carrying 1..10.
  - `in_ready_o` low from accept 10 until DONE+1.
- Upstream gaps (valid every third cycle): downscale still receives 10 contiguous cycles, identical data order.
- Exp model returns 10 results with random gaps < 256 cycles: 10 `out_valid_o` pulses, each 1 cycle after input; `out_last_o` and `frame_done_o` on the 10th only; `err_o` stays 0.
- Exp model returns only 9 results: 256 idle cycles after the 9th, `err_o` = 1 and `frame_done_o` pulses; no `out_last_o`; FILL follows.
- Inject `exp_valid_i` during FILL: not forwarded, `err_o` sticks at 1 until reset.
- Assert `reset_i` during ISSUE sample 5: next cycle all outputs 0, state FILL. A subsequent full frame completes normally with fresh data only.
